// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the round-robin UART scheduler, its requesters and the UART transmitter.
// master = scheduler side, slave = requesters/transmitter side.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ       = 4,
  parameter int BYTES_PER_MSG = 2
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ*BYTES_PER_MSG*8-1:0] req_msg;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               tx_start;
  logic [7:0]                         tx_data;
  logic                               tx_busy;
  logic                               tx_done;
  logic                               busy;
  logic                               msg_done;
  logic [1:0]                         msg_id;
  logic                               msg_error;

  modport master (
    input  req_valid, req_msg, tx_busy, tx_done,
    output req_ready, tx_start, tx_data, busy, msg_done, msg_id, msg_error
  );

  modport slave (
    output req_valid, req_msg, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data, busy, msg_done, msg_id, msg_error
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between NUM_REQ message requesters.
// Optional per-byte completion timeout enabled by defining UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int BYTES_PER_MSG  = 2,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input logic                 clock,
  input logic                 reset_n,
  uart_tx_scheduler_if.master bus
);
  localparam int         MSG_W     = BYTES_PER_MSG * 8;
  localparam logic [1:0] PTR_RESET = 2'(NUM_REQ - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_MSG - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, FINISH} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [1:0]       last_grant_reg, last_grant_next;
  logic [1:0]       msg_id_reg, msg_id_next;
  logic [MSG_W-1:0] msg_reg, msg_next;
  logic             pending_reg, pending_next;
  logic             done_q_reg;
  logic             done_edge;

  logic [3:0]       ready_vec;
  logic             tx_start_c;
  logic             msg_done_c;

  // Padded to four entries so the 2-bit indices fit every legal parameter set.
  logic [3:0]       valid_pad;
  logic [MSG_W-1:0] msg_pad [4];
  logic [7:0]       byte_pad [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NUM_REQ) begin : g_req
        assign valid_pad[gi] = bus.req_valid[gi];
        assign msg_pad[gi]   = bus.req_msg[gi*MSG_W +: MSG_W];
      end else begin : g_noreq
        assign valid_pad[gi] = 1'b0;
        assign msg_pad[gi]   = '0;
      end
      if (gi < BYTES_PER_MSG) begin : g_byte
        assign byte_pad[gi] = msg_reg[gi*8 +: 8];
      end else begin : g_nobyte
        assign byte_pad[gi] = 8'h00;
      end
    end
  endgenerate

  // First valid requester after the last one served, wrapping at NUM_REQ.
  logic       grant_found;
  logic [1:0] grant_idx;
  logic [2:0] cand;
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_reg} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!grant_found && valid_pad[cand[1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[1:0];
      end
    end
  end

  assign done_edge = bus.tx_done & ~done_q_reg;

`ifdef UART_SCHED_TIMEOUT_EN
  logic [15:0] cnt_reg, cnt_next;
  logic        timeout_hit;
  logic        msg_error_c;
  assign timeout_hit = (cnt_reg == 16'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    last_grant_next = last_grant_reg;
    msg_id_next     = msg_id_reg;
    msg_next        = msg_reg;
    pending_next    = pending_reg;
    ready_vec       = 4'b0000;
    tx_start_c      = 1'b0;
    msg_done_c      = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
    msg_error_c     = 1'b0;
    cnt_next        = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        pending_next = 1'b0;
        if (grant_found && !bus.tx_busy) begin
          ready_vec[grant_idx] = 1'b1;
          msg_next             = msg_pad[grant_idx];
          msg_id_next          = grant_idx;
          idx_next             = 2'd0;
          state_next           = START;
        end
      end
      START: begin
        tx_start_c   = 1'b1;
        pending_next = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
        cnt_next     = 16'd0;
`endif
        state_next   = WAIT;
      end
      WAIT: begin
        // A completed byte is remembered while the transmitter still reports busy.
        if (done_edge || pending_reg) begin
          if (idx_reg == LAST_BYTE) begin
            state_next = FINISH;
          end else if (!bus.tx_busy) begin
            idx_next   = idx_reg + 2'd1;
            state_next = START;
          end else begin
            pending_next = 1'b1;
          end
        end
`ifdef UART_SCHED_TIMEOUT_EN
        else if (timeout_hit) begin
          msg_error_c     = 1'b1;
          last_grant_next = msg_id_reg;
          state_next      = IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
`endif
      end
      FINISH: begin
        msg_done_c      = 1'b1;
        last_grant_next = msg_id_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= 2'd0;
      last_grant_reg <= PTR_RESET;
      msg_id_reg     <= 2'd0;
      msg_reg        <= '0;
      pending_reg    <= 1'b0;
      done_q_reg     <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      cnt_reg        <= 16'd0;
`endif
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      last_grant_reg <= last_grant_next;
      msg_id_reg     <= msg_id_next;
      msg_reg        <= msg_next;
      pending_reg    <= pending_next;
      done_q_reg     <= bus.tx_done;
`ifdef UART_SCHED_TIMEOUT_EN
      cnt_reg        <= cnt_next;
`endif
    end
  end

  // req_ready is decoded from live inputs, so it is masked while reset is held.
  assign bus.req_ready = ready_vec[NUM_REQ-1:0] & {NUM_REQ{reset_n}};
  assign bus.tx_start  = tx_start_c;
  assign bus.tx_data   = byte_pad[LAST_BYTE - idx_reg];
  assign bus.busy      = (state_reg != IDLE);
  assign bus.msg_done  = msg_done_c;
  assign bus.msg_id    = msg_id_reg;
`ifdef UART_SCHED_TIMEOUT_EN
  assign bus.msg_error = msg_error_c;
`else
  assign bus.msg_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: queued requesters and a behavioural transmitter, scored against a
// round-robin / byte-order reference model.
module tb_uart_tx_scheduler;
  localparam int NR  = 4;
  localparam int BPM = 2;
  localparam int MW  = BPM * 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  uart_tx_scheduler_if #(.NUM_REQ(NR), .BYTES_PER_MSG(BPM)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ(NR), .BYTES_PER_MSG(BPM), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [MW-1:0] rq [NR][$];
  int            grants [$];
  logic [7:0]    byte_log [$];
  int            ptr = NR - 1;
  int            cur_id = 0;
  logic [MW-1:0] cur_msg = '0;
  int            bytes_seen = 0;
  int            n_start = 0, n_done = 0, n_err = 0, stab_err = 0, cyc = 0;
  int            grant_cyc = 0, first_start_cyc = 0, last_start_cyc = 0, err_cyc = 0;
  int            last_done_id = 0, last_err_id = 0;
  logic          last_busy = 1'b0;
  bit            in_byte = 0;
  logic [7:0]    cap = 8'h00;
  logic          prev_done = 1'b0;
  int            pop_idx = -1;
  int            busy_len = 3, done_len = 1, tail_len = 0;
  bit            stall = 0, rand_tx = 0;
  int            ph = 0, cnt = 0, dcnt = 0, tcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    for (int k = 1; k <= NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = (rq[i].size() > 0);
      bus.req_msg[i*MW +: MW] = (rq[i].size() > 0) ? rq[i][0] : MW'($urandom);
    end
  endtask

  task automatic drive_tx(input logic started);
    if (started) begin
      if (rand_tx) begin
        busy_len = $urandom_range(1, 4);
        done_len = $urandom_range(1, 3);
        tail_len = $urandom_range(0, 2);
      end
      ph  = 1;
      cnt = busy_len;
    end
    if (ph == 1) begin
      if (cnt > 0) begin
        bus.tx_busy = 1'b1;
        bus.tx_done = 1'b0;
        if (!stall) cnt--;
      end else begin
        ph = 2; dcnt = done_len; tcnt = tail_len;
      end
    end
    if (ph == 2) begin
      bus.tx_done = (dcnt > 0);
      bus.tx_busy = (tcnt > 0);
      if (dcnt > 0) dcnt--;
      if (tcnt > 0) tcnt--;
      if (!bus.tx_done && !bus.tx_busy) ph = 0;
    end
    if (ph == 0) begin
      bus.tx_busy = 1'b0;
      bus.tx_done = 1'b0;
    end
  endtask

  // One clock: sample at the falling edge, score, then drive just after the rising edge.
  task automatic step();
    logic [NR-1:0] s_ready;
    logic          s_start, s_done, s_err;
    logic [7:0]    s_data;
    logic [1:0]    s_id;
    int            e;
    @(negedge clock);
    cyc++;
    s_ready = bus.req_ready; s_start = bus.tx_start; s_data = bus.tx_data;
    s_done = bus.msg_done; s_err = bus.msg_error; s_id = bus.msg_id; last_busy = bus.busy;
    if (in_byte) begin
      if (s_data !== cap) stab_err++;
      if (bus.tx_done && !prev_done) in_byte = 0;
    end
    pop_idx = -1;
    if (s_ready != '0) begin
      e = rr_pick(bus.req_valid, ptr);
      check("grant_onehot", 32'(s_ready), (e < 0) ? 32'd0 : 32'(1 << e));
      if (e >= 0) begin
        cur_id = e; cur_msg = rq[e][0]; pop_idx = e;
        grants.push_back(e);
      end
      bytes_seen = 0; grant_cyc = cyc;
    end
    if (s_start) begin
      n_start++;
      check("busy_at_start", 32'(last_busy), 32'd1);
      if (bytes_seen == 0) first_start_cyc = cyc;
      last_start_cyc = cyc;
      byte_log.push_back(s_data);
      if (bytes_seen < BPM) check("byte", 32'(s_data), 32'(cur_msg[(BPM-1-bytes_seen)*8 +: 8]));
      else check("byte_count", 32'(bytes_seen + 1), 32'(BPM));
      bytes_seen++;
      in_byte = 1; cap = s_data;
    end
    if (s_done) begin
      check("done_id", 32'(s_id), 32'(cur_id));
      check("done_bytes", 32'(bytes_seen), 32'(BPM));
      last_done_id = s_id; ptr = cur_id; n_done++;
    end
    if (s_err) begin
      last_err_id = s_id; err_cyc = cyc; ptr = cur_id; n_err++;
    end
    prev_done = bus.tx_done;
    @(posedge clock); #1;
    if (pop_idx >= 0) void'(rq[pop_idx].pop_front());
    drive_reqs();
    drive_tx(s_start);
  endtask

  task automatic run_until_done(input int target, input int budget, input string tag);
    int c = 0;
    while (n_done < target && c < budget) begin step(); c++; end
    check(tag, 32'(n_done), 32'(target));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    bus.req_valid = '0; bus.req_msg = '0; bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
    ph = 0; stall = 0; ptr = NR - 1; in_byte = 0; prev_done = 1'b0; bytes_seen = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int base_start, base_done, base_err, valid_cyc, pushed, total, c;

    // Reset state, with all requests raised to prove req_ready stays low.
    bus.req_valid = '1; bus.req_msg = '1; bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_msg_done", 32'(bus.msg_done), 32'd0);
    check("rst_msg_id", 32'(bus.msg_id), 32'd0);
    check("rst_msg_error", 32'(bus.msg_error), 32'd0);
    do_reset();

    // Single request A55A from requester 0.
    busy_len = 3; done_len = 1; tail_len = 0; rand_tx = 0;
    rq[0].push_back(16'hA55A); drive_reqs();
    valid_cyc = cyc + 1; byte_log.delete(); base_start = n_start;
    run_until_done(n_done + 1, 60, "single_done");
    check("single_grant_cycle", 32'(grant_cyc), 32'(valid_cyc));
    check("single_start_latency", 32'(first_start_cyc - valid_cyc), 32'd1);
    check("single_starts", 32'(n_start - base_start), 32'd2);
    check("single_log_size", 32'(byte_log.size()), 32'd2);
    if (byte_log.size() == 2) begin
      check("single_byte0", 32'(byte_log[0]), 32'hA5);
      check("single_byte1", 32'(byte_log[1]), 32'h5A);
    end
    check("single_msg_id", 32'(last_done_id), 32'd0);
    step();
    check("single_busy_after", 32'(last_busy), 32'd0);
    $display("single: grant@%0d start@%0d bytes=%0d", grant_cyc, first_start_cyc, byte_log.size());

    // Contention: all four requesters hold two messages each from reset.
    do_reset(); grants.delete();
    for (int i = 0; i < NR; i++) repeat (2) rq[i].push_back(MW'($urandom));
    drive_reqs();
    run_until_done(n_done + 8, 400, "contention_done");
    check("contention_count", 32'(grants.size()), 32'd8);
    for (int k = 0; k < 8 && k < grants.size(); k++)
      check("contention_order", 32'(grants[k]), 32'(k % NR));
    $display("contention: %0d grants", grants.size());

    // Long done level: three-cycle done pulses must not duplicate bytes.
    busy_len = 2; done_len = 3; tail_len = 0; base_start = n_start;
    rq[2].push_back(MW'($urandom)); drive_reqs();
    run_until_done(n_done + 1, 80, "longdone_done");
    repeat (6) step();
    check("longdone_starts", 32'(n_start - base_start), 32'd2);
    $display("longdone: starts=%0d", n_start - base_start);

    // Random arrivals against a randomised transmitter.
    rand_tx = 1; pushed = 0; base_done = n_done; stab_err = 0;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 5) == 0) begin
        c = $urandom_range(0, NR - 1);
        if (rq[c].size() < 3) begin rq[c].push_back(MW'($urandom)); pushed++; end
        drive_reqs();
      end
      step();
    end
    run_until_done(base_done + pushed, 3000, "random_drain");
    total = 0;
    for (int i = 0; i < NR; i++) total += rq[i].size();
    check("random_queues_empty", 32'(total), 32'd0);
    check("random_stability", 32'(stab_err), 32'd0);
    $display("random: pushed=%0d done=%0d", pushed, n_done - base_done);
    rand_tx = 0;

    // Reset in the middle of byte 0.
    busy_len = 2; done_len = 1; stall = 1; base_start = n_start;
    rq[3].push_back(16'hC33C); drive_reqs();
    c = 0;
    while (n_start == base_start && c < 20) begin step(); c++; end
    check("midrst_started", 32'(n_start - base_start), 32'd1);
    repeat (3) step();
    #3 reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_tx_data", 32'(bus.tx_data), 32'd0);
    check("midrst_msg_id", 32'(bus.msg_id), 32'd0);
    check("midrst_tx_start", 32'(bus.tx_start), 32'd0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    do_reset(); grants.delete(); busy_len = 2;
    rq[1].push_back(MW'($urandom)); rq[0].push_back(MW'($urandom)); drive_reqs();
    run_until_done(n_done + 2, 100, "midrst_after");
    if (grants.size() >= 2) begin
      check("midrst_first_grant", 32'(grants[0]), 32'd0);
      check("midrst_second_grant", 32'(grants[1]), 32'd1);
    end
    $display("midreset: grants after release=%0d", grants.size());

`ifdef UART_SCHED_TIMEOUT_EN
    // Transmitter never completes: abort 16 cycles after tx_start.
    do_reset(); stall = 1; busy_len = 1; base_err = n_err; base_done = n_done;
    rq[0].push_back(MW'($urandom)); drive_reqs();
    c = 0;
    while (n_err == base_err && c < 60) begin step(); c++; end
    check("timeout_errors", 32'(n_err - base_err), 32'd1);
    check("timeout_delay", 32'(err_cyc - last_start_cyc), 32'd16);
    check("timeout_msg_id", 32'(last_err_id), 32'd0);
    step();
    check("timeout_busy", 32'(last_busy), 32'd0);
    check("timeout_no_done", 32'(n_done - base_done), 32'd0);
    stall = 0; ph = 0; bus.tx_busy = 1'b0; grants.delete();
    rq[0].push_back(MW'($urandom)); rq[1].push_back(MW'($urandom)); drive_reqs();
    run_until_done(n_done + 2, 100, "timeout_recover");
    if (grants.size() >= 1) check("timeout_next_grant", 32'(grants[0]), 32'd1);
    $display("timeout: error after %0d cycles", err_cyc - last_start_cyc);
`else
    // Without the timeout the scheduler waits indefinitely and never raises msg_error.
    do_reset(); stall = 1; busy_len = 1; base_done = n_done;
    rq[0].push_back(MW'($urandom)); drive_reqs();
    repeat (60) step();
    check("nowait_still_busy", 32'(last_busy), 32'd1);
    check("nowait_no_done", 32'(n_done - base_done), 32'd0);
    check("nowait_no_error", 32'(n_err), 32'd0);
    $display("no-timeout: busy=%0d after 60 cycles", last_busy);
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART transmitter between up to 4 requesters (sensor readout, status, error reporting).
- Each requester offers a fixed-length message of BYTES_PER_MSG bytes through a valid/ready handshake.
- The block serialises the message byte-by-byte into the transmitter: start pulse, hold data, wait for done.
- It sits between the sensor/command logic and the UART transmitter, and is the only driver of the transmitter's has_data/data_to_send inputs.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..4.
BYTES_PER_MSG, 2, bytes per message; legal range 1..4; sent MSB byte first.
TIMEOUT_CYCLES, 2048, per-byte completion timeout in clocks; used only when UART_SCHED_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  NUM_REQ  bit i high: requester i holds a message.
req_msg  in  NUM_REQ*BYTES_PER_MSG*8  flattened messages; requester i occupies bits [i*BYTES_PER_MSG*8 +: BYTES_PER_MSG*8].
req_ready  out  NUM_REQ  one-cycle acceptance pulse to the granted requester.
tx_start  out  1  to transmitter has_data; one-cycle pulse per byte.
tx_data  out  8  to transmitter data_to_send; held stable for the whole byte.
tx_busy  in  1  from transmitter is_transmitting.
tx_done  in  1  from transmitter transmission_done; may stay high for more than one cycle.
busy  out  1  high from grant until message end.
msg_done  out  1  one-cycle pulse when all bytes of a message are sent.
msg_id  out  2  requester index of the current/last message; valid with msg_done and msg_error.
msg_error  out  1  one-cycle pulse on timeout abort; constant 0 without the macro.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - State IDLE; byte index 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 wins first.
  - Done-edge register 0.
- State machine: IDLE, START, WAIT, FINISH.
- IDLE:
  - If any req_valid and tx_busy==0: grant the first valid index searching last_grant+1, +2, ... modulo NUM_REQ.
  - On the grant: capture that requester's message into an internal shift/hold register, pulse req_ready[g] for exactly that cycle, set msg_id=g, busy=1, byte index=0, go to START.
  - Otherwise stay in IDLE.
  - req_msg is sampled only on the grant cycle; later changes are ignored.
- START:
  - Drive tx_data = message byte (BYTES_PER_MSG-1-idx); byte 0 is the most significant byte.
  - tx_start=1 for this cycle only; go to WAIT.
- WAIT:
  - tx_data held constant.
  - Completion is the rising edge of tx_done (tx_done & ~tx_done_q). A done level lasting several cycles counts once.
  - On completion: if idx==BYTES_PER_MSG-1, go to FINISH; otherwise idx+1 and go to START.
  - START is re-entered only when tx_busy==0. If tx_busy is still high, stay in WAIT until it falls.
- FINISH:
  - msg_done=1 for one cycle; last_grant=msg_id; busy=0; go to IDLE.
  - The next grant can occur on the following cycle, giving a minimum 1-cycle gap between messages.
- Latency: req_valid to first tx_start is 2 cycles (grant cycle, then START).
- Simultaneous requests: exactly one grant per IDLE visit. A requester that is never granted keeps req_valid high; the fairness bound is NUM_REQ-1 messages.
- A requester dropping req_valid before its grant is simply skipped. Dropping it after the grant has no effect.
- tx_done while in IDLE, START or FINISH is ignored; the edge register still updates every cycle.
- Reset asserted mid-message: immediate abort, all outputs 0 asynchronously, no msg_done, pointer back to the reset value.

Optional Feature:
UART_SCHED_TIMEOUT_EN:
- Defined:
  - A 16-bit counter clears on every START and increments in WAIT.
  - If it reaches TIMEOUT_CYCLES-1 without a completion edge: abort the rest of the message, pulse msg_error (msg_id valid), set last_grant=msg_id, busy=0, go to IDLE. No msg_done is pulsed.
  - A completion edge on the same cycle as the timeout wins, and no error is raised.
- Not defined: no counter; WAIT waits indefinitely; msg_error is tied 0.

Test Plan:
- Single request: req_valid=4'b0001, msg 16'hA55A -> req_ready[0] pulse; tx_start pulses twice; tx_data A5 then 5A; msg_done with msg_id=0.
- Contention: all four valid continuously after reset -> grant order 0,1,2,3,0; each msg_id appears once per 4 messages.
- Long done: tx_done held high 3 cycles per byte -> exactly 2 bytes per message, no duplicate tx_start.
- Stability: tx_data is constant from tx_start until the done edge. Changing req_msg after req_ready does not alter the transmitted bytes.
- Reset mid-byte: reset_n low during WAIT of byte 0 -> outputs 0 immediately; after release, requester 0 is granted first again.
- Timeout (macro defined, TIMEOUT_CYCLES=16): tx_done never asserted -> msg_error pulse 16 cycles after tx_start, busy=0; next grant goes to the next requester.
